// File: rtl/fifo_rd_streamer.sv
// Read-side drain stage for the 16x8 FIFO: issues read strobes, captures registered dout and
// re-presents words on a valid/ready stream. Optional parity storage via `FIFO_RD_PARITY_EN.
module fifo_rd_streamer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OBUF_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              fifo_wr_mon,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef FIFO_RD_PARITY_EN
  output logic              out_parity,
`endif
  output logic [CNT_W-1:0]  out_count
);

  localparam int unsigned PTR_W = $clog2(OBUF_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned RES_W = OCC_W + 1;
`ifdef FIFO_RD_PARITY_EN
  localparam int unsigned ENT_W = DATA_W + 1;
`else
  localparam int unsigned ENT_W = DATA_W;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENT_W-1:0]   buf_q [OBUF_DEPTH];

  logic               rd_req;
  logic               accept;
  logic               push;
  logic               pop;
  logic [RES_W-1:0]   reserved;
  logic [ENT_W-1:0]   entry;
  logic [ENT_W-1:0]   head;

  // Slots already owned = stored words plus the one word still in flight from the FIFO.
  assign reserved = RES_W'(occ_q) + RES_W'(state_q == S_WAIT);
  assign rd_req   = !rst && !fifo_empty && (reserved < RES_W'(OBUF_DEPTH));
  // The FIFO drops a read whenever it performs a write in the same cycle.
  assign accept   = rd_req && !(fifo_wr_mon && !fifo_full);
  assign push     = (state_q == S_WAIT);
  assign pop      = out_valid && out_ready;

`ifdef FIFO_RD_PARITY_EN
  assign entry = {^fifo_dout, fifo_dout};
`else
  assign entry = fifo_dout;
`endif

  assign head      = buf_q[rd_ptr_q];
  assign fifo_rd   = rd_req;
  assign out_valid = (occ_q != '0);
  assign out_data  = head[DATA_W-1:0];
  assign out_count = cnt_q;
`ifdef FIFO_RD_PARITY_EN
  assign out_parity = head[DATA_W];
`endif

  always_comb begin
    state_d  = accept ? S_WAIT : S_IDLE;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d    = cnt_q + CNT_W'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        buf_q[wr_ptr_q] <= entry;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Randomized bench for fifo_rd_streamer: behavioural FIFO environment plus an in-order
// word scoreboard that applies the two-cycle visibility rule and the reservation limit.
module tb_fifo_rd_streamer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_wr_mon;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
`ifdef FIFO_RD_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  fifo_rd_streamer #(
    .DATA_W    (DW),
    .OBUF_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_wr_mon(fifo_wr_mon),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef FIFO_RD_PARITY_EN
    .out_parity (out_parity),
`endif
    .out_count  (out_count)
  );

  typedef struct {
    logic [DW-1:0] w;
    int unsigned   vis;
  } exp_t;

  logic [DW-1:0] fq[$];
  exp_t          mq[$];
  int unsigned   cyc;
  int unsigned   outstanding;
  int unsigned   hs_cnt;
  int unsigned   gen_val;
  bit            autofill;
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic upd_flags();
    fifo_empty = (fq.size() == 0);
    fifo_full  = (fq.size() >= 16);
  endtask

  task automatic preload(input logic [DW-1:0] w);
    if (fq.size() < 16) fq.push_back(w);
    upd_flags();
  endtask

  task automatic model_clear();
    mq.delete();
    outstanding = 0;
    hs_cnt      = 0;
  endtask

  // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic tick(input bit wr, input logic [DW-1:0] wd, input bit rdy);
    logic rd_s, full_s, empty_s, acc, hs, exp_v, did_rd;
    fifo_wr_mon = wr;
    out_ready   = rdy;
    #3;
    exp_v = (mq.size() > 0) && (mq[0].vis <= cyc);
    check("fifo_rd", fifo_rd, (!rst && !fifo_empty && outstanding < DEPTH));
    check("out_valid", out_valid, exp_v);
    if (exp_v) begin
      check("out_data", out_data, mq[0].w);
`ifdef FIFO_RD_PARITY_EN
      check("out_parity", out_parity, ^mq[0].w);
`endif
    end
    check("out_count", out_count, hs_cnt[15:0]);
    rd_s    = fifo_rd;
    full_s  = fifo_full;
    empty_s = fifo_empty;
    acc     = rd_s && !(wr && !full_s);
    hs      = out_valid && rdy && !rst;
    @(posedge clk);
    #1;
    did_rd = 1'b0;
    if (wr && !full_s) begin
      fq.push_back(wd);
    end else if (rd_s && !empty_s) begin
      fifo_dout = fq.pop_front();
      did_rd    = 1'b1;
    end
    if (!did_rd) fifo_dout = DW'($urandom);
    if (acc && !rst) begin
      mq.push_back('{w: fifo_dout, vis: cyc + 2});
      outstanding++;
    end
    if (hs && mq.size() > 0) begin
      void'(mq.pop_front());
      outstanding--;
      hs_cnt++;
    end
    if (autofill) begin
      while (fq.size() < 16) begin
        fq.push_back(DW'(gen_val));
        gen_val++;
      end
    end
    cyc++;
    upd_flags();
  endtask

  task automatic run(input int n, input int wr_pct, input int rdy_pct);
    for (int i = 0; i < n; i++) begin
      tick(($urandom_range(99) < wr_pct), DW'($urandom), ($urandom_range(99) < rdy_pct));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    gen_val     = 0;
    autofill    = 1'b0;
    rst         = 1'b1;
    fifo_wr_mon = 1'b0;
    out_ready   = 1'b0;
    fifo_dout   = '0;
    model_clear();
    upd_flags();
    @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_count", out_count, 16'h0000);
    check("rst_rd", fifo_rd, 1'b0);
`ifdef FIFO_RD_PARITY_EN
    check("rst_parity", out_parity, 1'b0);
`endif
    preload(8'h55);
    tick(1'b0, '0, 1'b1);
    check("rst_rd_nonempty", fifo_rd, 1'b0);
    rst = 1'b0;

    // Short stream: 0x55 left over plus 0x11,0x22,0x33 at full rate.
    preload(8'h11);
    preload(8'h22);
    preload(8'h33);
    drain(8);
    check("short_drained", mq.size(), 0);

    // Backpressure: only four reads may be outstanding.
    for (int i = 0; i < 10; i++) preload(DW'(8'hA0 + i));
    for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b0);
    check("hold_outstanding", outstanding, 4);
    check("hold_fifo_left", fq.size(), 6);
    check("hold_head", out_data, 8'hA0);
    drain(20);
    check("hold_drained", mq.size(), 0);

    // Random traffic with write/read collisions, light and heavy loads.
    run(800, 50, 75);
    run(600, 90, 30);
    run(600, 20, 95);
    drain(30);
    check("rand_drained", mq.size(), 0);

    // Reset while one word is in flight and three are buffered.
    for (int i = 0; i < 8; i++) preload(DW'(8'hC0 + i));
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0);
    check("pre_rst_outstanding", outstanding, 4);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_count", out_count, 16'h0000);
    check("mid_rst_rd", fifo_rd, 1'b0);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    rst = 1'b0;
    drain(20);
    check("post_rst_drained", mq.size(), 0);
    check("post_rst_count", out_count, 16'd4);

    // Parity words.
    preload(8'h07);
    preload(8'h03);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    check("par_head", out_data, 8'h07);
`ifdef FIFO_RD_PARITY_EN
    check("par_07", out_parity, 1'b1);
`endif
    tick(1'b0, '0, 1'b1);
    check("par_next", out_data, 8'h03);
`ifdef FIFO_RD_PARITY_EN
    check("par_03", out_parity, 1'b0);
`endif
    drain(6);

    // Counter wrap under a continuous source.
    autofill = 1'b1;
    upd_flags();
    for (int g = 0; g < 70000 && hs_cnt < 65535; g++) tick(1'b0, '0, 1'b1);
    check("cnt_max", out_count, 16'hFFFF);
    tick(1'b0, '0, 1'b1);
    check("cnt_wrap", out_count, 16'h0000);
    drain(20);
    autofill = 1'b0;
    drain(40);
    check("final_drained", mq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
